// File: rtl/vga_timing_ctrl_pkg.sv
// Shared VGA timing constants, sync bundle type and window helper for the
// timing generator and the character renderer that must agree on offsets.
package vga_timing_ctrl_pkg;

  localparam int CNT_W        = 10;
  localparam int H_TOTAL_DEF  = 800;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_ACT_ST_DEF = 143;
  localparam int V_TOTAL_DEF  = 525;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_ACT_ST_DEF = 35;
  localparam int H_ACT        = 640;
  localparam int V_ACT        = 480;

  // Colour field positions inside the 12-bit {B,G,R} pixel word.
  localparam int COL_W = 4;
  localparam int R_LSB = 0;
  localparam int G_LSB = 4;
  localparam int B_LSB = 8;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0};

  function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                     input logic [CNT_W-1:0] first,
                                     input logic [CNT_W-1:0] last_excl);
    return (cnt >= first) && (cnt < last_excl);
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// Divides clk into a one-cycle pixel enable strobe every DIV cycles.
module clk_en_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic pix_en
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign pix_en = !rst && (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// 640x480 VGA timing generator: raw counters for the renderer, sync/active
// delay pipe matching renderer latency, and registered RGB/sync pins.
module vga_timing_ctrl
  import vga_timing_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = 1,
  parameter int PIPE_DLY = 2,
  parameter int H_TOTAL  = H_TOTAL_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_ACT_ST = H_ACT_ST_DEF,
  parameter int V_TOTAL  = V_TOTAL_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_ACT_ST = V_ACT_ST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] pixel_in,
  output logic [9:0]  h_count,
  output logic [9:0]  v_count,
  output logic        pix_en,
  output logic        video_on,
  output logic        frame_start,
  output logic        hs,
  output logic        vs,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYN_C = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYN_C = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_FIRST = CNT_W'(H_ACT_ST);
  localparam logic [CNT_W-1:0] H_END   = CNT_W'(H_ACT_ST + H_ACT);
  localparam logic [CNT_W-1:0] V_FIRST = CNT_W'(V_ACT_ST);
  localparam logic [CNT_W-1:0] V_END   = CNT_W'(V_ACT_ST + V_ACT);

  clk_en_div #(.DIV(CLK_DIV)) u_div (
    .clk    (clk),
    .rst    (rst),
    .pix_en (pix_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      h_count     <= '0;
      v_count     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        if (h_count == H_LAST) begin
          h_count <= '0;
          if (v_count == V_LAST) begin
            v_count     <= '0;
            frame_start <= 1'b1;
          end else begin
            v_count <= v_count + 1'b1;
          end
        end else begin
          h_count <= h_count + 1'b1;
        end
      end
    end
  end

  assign video_on = in_window(h_count, H_FIRST, H_END) && in_window(v_count, V_FIRST, V_END);

  sync_t raw;
  sync_t tail;

  assign raw = '{hs: (h_count >= H_SYN_C), vs: (v_count >= V_SYN_C), act: video_on};

  // The pipe lines the syncs up with pixels the renderer returns PIPE_DLY pixels late.
  generate
    if (PIPE_DLY == 0) begin : g_direct
      assign tail = raw;
    end else begin : g_pipe
      sync_t stage [PIPE_DLY];

      // NOTE: the few pipe stages are reset so no stale active flag leaks colour after reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PIPE_DLY; i++) stage[i] <= SYNC_IDLE;
        end else if (pix_en) begin
          stage[0] <= raw;
          for (int i = 1; i < PIPE_DLY; i++) stage[i] <= stage[i-1];
        end
      end

      assign tail = stage[PIPE_DLY-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      hs    <= 1'b1;
      vs    <= 1'b1;
      vga_r <= '0;
      vga_g <= '0;
      vga_b <= '0;
    end else if (pix_en) begin
      hs    <= tail.hs;
      vs    <= tail.vs;
      vga_r <= tail.act ? pixel_in[R_LSB +: COL_W] : '0;
      vga_g <= tail.act ? pixel_in[G_LSB +: COL_W] : '0;
      vga_b <= tail.act ? pixel_in[B_LSB +: COL_W] : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Self-checking bench: three configurations run against a pixel-index model.
module tb_vga_timing_ctrl;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        pe;
    logic        vo;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pixel_in;

  logic [9:0] m_h, m_v, s_h, s_v, d_h, d_v;
  logic m_pe, m_vo, m_fs, m_hs, m_vs;
  logic s_pe, s_vo, s_fs, s_hs, s_vs;
  logic d_pe, d_vo, d_fs, d_hs, d_vs;
  logic [3:0] m_r, m_g, m_b, s_r, s_g, s_b, d_r, d_g, d_b;

  int checks = 0;
  int errors = 0;
  int c = 0;
  logic [11:0] pix_hist [0:32767];

  always #5 clk = ~clk;

  vga_timing_ctrl #(.CLK_DIV(1), .PIPE_DLY(2)) u_main (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .h_count(m_h), .v_count(m_v),
    .pix_en(m_pe), .video_on(m_vo), .frame_start(m_fs), .hs(m_hs), .vs(m_vs),
    .vga_r(m_r), .vga_g(m_g), .vga_b(m_b));

  vga_timing_ctrl #(.CLK_DIV(1), .PIPE_DLY(0), .H_TOTAL(20), .H_SYNC(4), .H_ACT_ST(3),
                    .V_TOTAL(10), .V_SYNC(2), .V_ACT_ST(2)) u_small (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .h_count(s_h), .v_count(s_v),
    .pix_en(s_pe), .video_on(s_vo), .frame_start(s_fs), .hs(s_hs), .vs(s_vs),
    .vga_r(s_r), .vga_g(s_g), .vga_b(s_b));

  vga_timing_ctrl #(.CLK_DIV(4), .PIPE_DLY(2)) u_div4 (
    .clk(clk), .rst(rst), .pixel_in(pixel_in), .h_count(d_h), .v_count(d_v),
    .pix_en(d_pe), .video_on(d_vo), .frame_start(d_fs), .hs(d_hs), .vs(d_vs),
    .vga_r(d_r), .vga_g(d_g), .vga_b(d_b));

  // Expected outputs after c clock edges since reset release, from pixel-index arithmetic.
  function automatic exp_t model(input int cc, input logic r, input int d, input int p,
                                 input int ht, input int hsy, input int hst,
                                 input int vt, input int vsy, input int vst);
    exp_t e;
    int k, idx, hh, vv, ch, cv;
    k   = cc / d;
    ch  = k % ht;
    cv  = (k / ht) % vt;
    e.h  = 10'(ch);
    e.v  = 10'(cv);
    e.pe = !r && (cc % d == d - 1);
    e.vo = (ch >= hst) && (ch < hst + 640) && (cv >= vst) && (cv < vst + 480);
    e.fs = (k > 0) && (cc % d == 0) && (k % (ht * vt) == 0);
    idx = k - 1 - p;
    if (idx < 0) begin
      e.hs  = 1'b1;
      e.vs  = 1'b1;
      e.rgb = 12'h000;
    end else begin
      hh = idx % ht;
      vv = (idx / ht) % vt;
      e.hs  = (hh >= hsy);
      e.vs  = (vv >= vsy);
      e.rgb = ((hh >= hst) && (hh < hst + 640) && (vv >= vst) && (vv < vst + 480))
              ? pix_hist[k * d] : 12'h000;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at c=%0d: observed %0h expected %0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_all(input string nm, input exp_t e, input logic [9:0] h, input logic [9:0] v,
                           input logic pe, input logic vo, input logic fs, input logic hs_o,
                           input logic vs_o, input logic [11:0] rgb);
    check({nm, ".h"},   32'(h),    32'(e.h));
    check({nm, ".v"},   32'(v),    32'(e.v));
    check({nm, ".pe"},  32'(pe),   32'(e.pe));
    check({nm, ".vo"},  32'(vo),   32'(e.vo));
    check({nm, ".fs"},  32'(fs),   32'(e.fs));
    check({nm, ".hs"},  32'(hs_o), 32'(e.hs));
    check({nm, ".vs"},  32'(vs_o), 32'(e.vs));
    check({nm, ".rgb"}, 32'(rgb),  32'(e.rgb));
  endtask

  // One clock: drive pixel, advance, then compare all instances at the falling edge.
  task automatic step(input logic [11:0] px);
    pixel_in = px;
    @(posedge clk);
    if (rst) c = 0;
    else c++;
    if (c < 32768) pix_hist[c] = px;
    @(negedge clk);
    check_all("main",  model(c, rst, 1, 2, 800, 96, 143, 525, 2, 35),
              m_h, m_v, m_pe, m_vo, m_fs, m_hs, m_vs, {m_b, m_g, m_r});
    check_all("small", model(c, rst, 1, 0, 20, 4, 3, 10, 2, 2),
              s_h, s_v, s_pe, s_vo, s_fs, s_hs, s_vs, {s_b, s_g, s_r});
    check_all("div4",  model(c, rst, 4, 2, 800, 96, 143, 525, 2, 35),
              d_h, d_v, d_pe, d_vo, d_fs, d_hs, d_vs, {d_b, d_g, d_r});
  endtask

  // Solid blue around h=143 on lines 34/35 of the main display, random elsewhere.
  function automatic logic [11:0] pick_px(input int cc);
    int idx, hh, vv;
    idx = cc - 3;
    hh  = idx % 800;
    vv  = idx / 800;
    if (idx >= 0 && (vv == 34 || vv == 35) && hh >= 130 && hh <= 150) return 12'hF00;
    return 12'($urandom);
  endfunction

  initial begin
    int hs_low;
    int fs_cnt;
    int pe_cnt;
    hs_low = 0;
    fs_cnt = 0;
    pe_cnt = 0;
    rst = 1'b1;
    pixel_in = 12'h000;
    @(negedge clk);
    repeat (3) step(12'($urandom));
    check("rst.h", 32'(m_h), 32'd0);
    check("rst.hs", 32'(m_hs), 32'd1);
    rst = 1'b0;

    // Free run across the first line wrap.
    for (int i = 0; i < 1000; i++) begin
      step(12'($urandom));
      if (c >= 10 && c <= 809 && !m_hs) hs_low++;
      if (c == 799) begin
        check("wrap.h799", 32'(m_h), 32'd799);
        check("wrap.v0", 32'(m_v), 32'd0);
      end
      if (c == 800) begin
        check("wrap.h0", 32'(m_h), 32'd0);
        check("wrap.v1", 32'(m_v), 32'd1);
      end
    end
    check("hs_low_cnt", 32'(hs_low), 32'd96);

    // Mid-line reset held three clocks.
    rst = 1'b1;
    repeat (3) step(12'($urandom));
    check("mid_rst.h", 32'(m_h), 32'd0);
    check("mid_rst.v", 32'(m_v), 32'd0);
    check("mid_rst.hs", 32'(m_hs), 32'd1);
    check("mid_rst.vs", 32'(m_vs), 32'd1);
    check("mid_rst.rgb", 32'({m_b, m_g, m_r}), 32'd0);
    check("mid_rst.fs", 32'(m_fs), 32'd0);
    rst = 1'b0;

    // Run into the active window and probe its top-left corner.
    while (c < 28400) begin
      step(pick_px(c + 1));
      if (c == 28146) begin
        check("corner.rgb", 32'({m_b, m_g, m_r}), 32'h00000F00);
        check("corner.b", 32'(m_b), 32'hF);
      end
      if (c == 28145) check("h142.rgb", 32'({m_b, m_g, m_r}), 32'd0);
      if (c == 27346) check("v34.rgb", 32'({m_b, m_g, m_r}), 32'd0);
    end
    check("active.vo", 32'(m_vo), 32'd1);

    // Reset at h=400 inside the active area, then restart.
    rst = 1'b1;
    step(12'hF00);
    rst = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      step((c < 5) ? 12'hF00 : 12'($urandom));
      if (c >= 1 && c <= 3) check("post_rst.rgb", 32'({m_b, m_g, m_r}), 32'd0);
      if (c >= 1 && c <= 200 && s_fs) fs_cnt++;
      if (c == 200) begin
        check("frame.h", 32'(s_h), 32'd0);
        check("frame.v", 32'(s_v), 32'd0);
      end
      if (c >= 1 && c <= 40 && d_pe) pe_cnt++;
      if (c == 4) check("div4.h_c4", 32'(d_h), 32'd1);
      if (c == 7) check("div4.h_c7", 32'(d_h), 32'd1);
      if (c == 8) check("div4.h_c8", 32'(d_h), 32'd2);
    end
    check("frame.pulses", 32'(fs_cnt), 32'd1);
    check("div4.pe_cnt", 32'(pe_cnt), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
